// File: rtl/div_pkg.sv
// div_pkg: op and state encodings plus a shared negate helper for the divide unit
package div_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;
    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_DONE = 2'b10
    } div_state_e;
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction
endpackage

// File: rtl/div.sv
// div: multi-cycle RV32M divide unit, radix-2 restoring, one quotient bit per cycle
module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_start_i,
    input  logic [1:0]        div_op_i,
    input  logic [DATA_W-1:0] div_dividend_i,
    input  logic [DATA_W-1:0] div_divisor_i,
    input  logic [4:0]        div_rd_addr_i,
    input  logic              div_abort_i,
    output logic              div_hold_flag_o,
    output logic              div_busy_o,
    output logic              div_ready_o,
    output logic [DATA_W-1:0] div_result_o,
    output logic [4:0]        div_rd_addr_o,
    output logic              div_we_o
);
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    div_state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d, rd_q, rd_d;
    logic rem_sel_q, rem_sel_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
    logic is_signed, sa, sb, accept;
    logic [DATA_W:0] sh, diff;
    always_comb begin
        is_signed = div_op_i == DIV_OP_DIV || div_op_i == DIV_OP_REM;
        sa = is_signed & div_dividend_i[DATA_W-1];
        sb = is_signed & div_divisor_i[DATA_W-1];
        accept = state_q == DIV_ST_IDLE && div_start_i && !div_abort_i;
        // one restoring step: diff[DATA_W] set means the trial subtract went negative
        sh = {rem_q, a_q[DATA_W-1]};
        diff = sh - {1'b0, b_q};
        state_d = state_q;
        cnt_d = cnt_q;
        rd_d = rd_q;
        rem_sel_d = rem_sel_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        a_d = a_q;
        b_d = b_q;
        quo_d = quo_q;
        rem_d = rem_q;
        if (div_abort_i) begin
            state_d = DIV_ST_IDLE;
        end else if (accept) begin
            rem_sel_d = div_op_i == DIV_OP_REM || div_op_i == DIV_OP_REMU;
            rd_d = div_rd_addr_i;
            cnt_d = '0;
            a_d = neg_if(sa, div_dividend_i);
            b_d = neg_if(sb, div_divisor_i);
            quo_d = '0;
            rem_d = '0;
            neg_q_d = sa ^ sb;
            neg_r_d = sa;
            state_d = DIV_ST_CALC;
            // special cases bypass iteration and must not be sign-corrected
            if (div_divisor_i == '0) begin
                quo_d = '1;
                rem_d = div_dividend_i;
                neg_q_d = 1'b0;
                neg_r_d = 1'b0;
                state_d = DIV_ST_DONE;
            end else if (is_signed && div_dividend_i == INT_MIN && div_divisor_i == '1) begin
                quo_d = INT_MIN;
                neg_q_d = 1'b0;
                neg_r_d = 1'b0;
                state_d = DIV_ST_DONE;
            end
        end else if (state_q == DIV_ST_CALC) begin
            a_d = a_q << 1;
            rem_d = diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
            cnt_d = cnt_q + 5'd1;
            state_d = cnt_q == 5'd31 ? DIV_ST_DONE : DIV_ST_CALC;
        end else if (state_q == DIV_ST_DONE) begin
            state_d = DIV_ST_IDLE;
        end
    end
    always_comb begin
        div_busy_o = state_q != DIV_ST_IDLE;
        div_hold_flag_o = accept || (state_q == DIV_ST_CALC && !div_abort_i);
        div_ready_o = state_q == DIV_ST_DONE && !div_abort_i;
        div_we_o = div_ready_o;
        div_rd_addr_o = rd_q;
        div_result_o = !div_ready_o ? '0 : rem_sel_q ? neg_if(neg_r_q, rem_q) : neg_if(neg_q_q, quo_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_ST_IDLE;
            cnt_q <= '0;
            rd_q <= '0;
            rem_sel_q <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rd_q <= rd_d;
            rem_sel_q <= rem_sel_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            a_q <= a_d;
            b_q <= b_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end
endmodule
